// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end that time-shares one 16-bit ALU and returns tagged results.
// Optional opcode screening is enabled with `define ALU_SHARE_ARBITER_OPCHECK_EN.
module alu_share_arbiter #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_sub,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_sub,

    output logic [15:0] alu_valA,
    output logic [15:0] alu_valB,
    output logic [3:0]  alu_op,
    output logic        alu_sub,
    input  logic [15:0] alu_result,
    input  logic [3:0]  alu_cc,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_cc,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] LatCnt = 4'(ALU_LATENCY);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        sub_q, sub_d;
    logic        id_q, id_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  cc_q, cc_d;

    logic        gnt_id;
    logic        accept;
    logic [3:0]  gnt_op;
    logic [15:0] gnt_a;
    logic [15:0] gnt_b;
    logic        gnt_sub;

    // On a tie the requester that did not win last time gets the grant.
    assign gnt_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign gnt_op  = gnt_id ? req1_op  : req0_op;
    assign gnt_a   = gnt_id ? req1_a   : req0_a;
    assign gnt_b   = gnt_id ? req1_b   : req0_b;
    assign gnt_sub = gnt_id ? req1_sub : req0_sub;

    assign req0_ready = ~reset && (state_q == StIdle) && req0_valid && !gnt_id;
    assign req1_ready = ~reset && (state_q == StIdle) && req1_valid &&  gnt_id;
    assign accept     = req0_ready || req1_ready;

`ifdef ALU_SHARE_ARBITER_OPCHECK_EN
    logic err_q, err_d;
    logic op_bad;

    assign op_bad  = gnt_op inside {4'b0000, 4'b0011, 4'b0100, 4'b1010};
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        sub_d        = sub_q;
        id_d         = id_q;
        result_d     = result_q;
        cc_d         = cc_q;
`ifdef ALU_SHARE_ARBITER_OPCHECK_EN
        err_d        = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    last_grant_d = gnt_id;
                    id_d         = gnt_id;
                    cnt_d        = LatCnt;
                    op_d         = gnt_op;
                    a_d          = gnt_a;
                    b_d          = gnt_b;
                    sub_d        = gnt_sub;
                    state_d      = StExec;
`ifdef ALU_SHARE_ARBITER_OPCHECK_EN
                    err_d        = op_bad;
                    // Rejected opcodes never reach the ALU; its inputs keep the previous command.
                    if (op_bad) begin
                        op_d     = op_q;
                        a_d      = a_q;
                        b_d      = b_q;
                        sub_d    = sub_q;
                        result_d = '0;
                        cc_d     = '0;
                        state_d  = StResp;
                    end
`endif
                end
            end
            StExec: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = alu_result;
                    cc_d     = alu_cc;
                    state_d  = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            id_q         <= 1'b0;
            result_q     <= '0;
            cc_q         <= '0;
`ifdef ALU_SHARE_ARBITER_OPCHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sub_q        <= sub_d;
            id_q         <= id_d;
            result_q     <= result_d;
            cc_q         <= cc_d;
`ifdef ALU_SHARE_ARBITER_OPCHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign alu_valA   = a_q;
    assign alu_valB   = b_q;
    assign alu_op     = op_q;
    assign alu_sub    = sub_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_cc     = cc_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance at ALU_LATENCY=1, one at ALU_LATENCY=3.
// Opcode screening checks are compiled in when ALU_SHARE_ARBITER_OPCHECK_EN is defined.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference ALU: 0001 ADD/SUB, 0010 SUB, 0101 AND, 0111 XOR, 1000 SHL, 1111 MUL; cc = {N, Z, 0, 0}.
    function automatic logic [19:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic sub);
        logic [15:0] r;
        case (op)
            4'b0001: r = sub ? a - b : a + b;
            4'b0010: r = a - b;
            4'b0101: r = a & b;
            4'b0111: r = a ^ b;
            4'b1000: r = a << b[3:0];
            4'b1111: r = a * b;
            default: r = 16'h0000;
        endcase
        return {r[15], (r == 16'h0000), 2'b00, r};
    endfunction

    // Instance under test at ALU_LATENCY=1
    logic        req0_valid = 0, req1_valid = 0, req0_sub = 0, req1_sub = 0;
    logic [3:0]  req0_op = 0, req1_op = 0;
    logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_ready, req1_ready;
    logic [15:0] alu_valA, alu_valB, alu_result, rsp_result;
    logic [3:0]  alu_op, alu_cc, rsp_cc;
    logic        alu_sub, rsp_valid, rsp_id, rsp_err, busy;
    logic        rsp_ready = 1'b1;

    assign {alu_cc, alu_result} = alu_model(alu_op, alu_valA, alu_valB, alu_sub);

    alu_share_arbiter #(.ALU_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .alu_valA(alu_valA), .alu_valB(alu_valB), .alu_op(alu_op), .alu_sub(alu_sub),
        .alu_result(alu_result), .alu_cc(alu_cc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cc(rsp_cc), .rsp_err(rsp_err), .busy(busy)
    );

    // Second instance at ALU_LATENCY=3, driven only from requester 0
    logic        r3_valid = 0, r3_ready, r3_ready1;
    logic [15:0] r3_valA, r3_valB, r3_alu_result, r3_rsp_result;
    logic [3:0]  r3_op, r3_alu_cc, r3_rsp_cc;
    logic        r3_sub, r3_rsp_valid, r3_rsp_id, r3_rsp_err, r3_busy;
    logic [3:0]  r3_req_op = 0;
    logic [15:0] r3_req_a = 0, r3_req_b = 0;

    assign {r3_alu_cc, r3_alu_result} = alu_model(r3_op, r3_valA, r3_valB, r3_sub);

    alu_share_arbiter #(.ALU_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0_valid(r3_valid), .req0_ready(r3_ready), .req0_op(r3_req_op),
        .req0_a(r3_req_a), .req0_b(r3_req_b), .req0_sub(1'b0),
        .req1_valid(1'b0), .req1_ready(r3_ready1), .req1_op(4'h0),
        .req1_a(16'h0000), .req1_b(16'h0000), .req1_sub(1'b0),
        .alu_valA(r3_valA), .alu_valB(r3_valB), .alu_op(r3_op), .alu_sub(r3_sub),
        .alu_result(r3_alu_result), .alu_cc(r3_alu_cc),
        .rsp_valid(r3_rsp_valid), .rsp_ready(1'b1), .rsp_id(r3_rsp_id),
        .rsp_result(r3_rsp_result), .rsp_cc(r3_rsp_cc), .rsp_err(r3_rsp_err), .busy(r3_busy)
    );

    // Handshake monitor, sampled on the falling edge while inputs are stable
    logic mon_en = 1'b0;
    int   grants[$];
    int   rsp_ids[$];
    int   rsp_results[$];
    always @(negedge clk) begin
        if (mon_en) begin
            if (req0_valid && req0_ready) grants.push_back(0);
            if (req1_valid && req1_ready) grants.push_back(1);
            if (rsp_valid && rsp_ready) begin
                rsp_ids.push_back(int'(rsp_id));
                rsp_results.push_back(int'(rsp_result));
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            cyc();
            n++;
        end
        check_eq({tag, "_rsp_timeout"}, 32'(rsp_valid), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready0"}, 32'(req0_ready), 0);
        check_eq({tag, "_ready1"}, 32'(req1_ready), 0);
        check_eq({tag, "_alu"}, {alu_valA, alu_valB}, 0);
        check_eq({tag, "_aluop"}, {27'd0, alu_op, alu_sub}, 0);
        check_eq({tag, "_rsp"}, {10'd0, rsp_valid, rsp_id, rsp_result, rsp_cc}, 0);
        check_eq({tag, "_busy_err"}, {30'd0, busy, rsp_err}, 0);
    endtask

    initial begin
        // Reset state, with requester 0 already asserting valid
        req0_valid = 1;
        #1;
        check_reset_outputs("reset");
        req0_valid = 0;
        cyc();
        reset = 0;

        // Single request: ADD 25000 + 30000
        cyc();
        req0_valid = 1; req0_op = 4'b0001; req0_a = 16'd25000; req0_b = 16'd30000; req0_sub = 0;
        #1;
        check_eq("single_ready0", 32'(req0_ready), 1);
        check_eq("single_ready1", 32'(req1_ready), 0);
        check_eq("single_idle", 32'(busy), 0);
        cyc();
        req0_valid = 0;
        #1;
        check_eq("single_exec_busy", 32'(busy), 1);
        check_eq("single_exec_norsp", 32'(rsp_valid), 0);
        check_eq("single_alu_a", 32'(alu_valA), 25000);
        check_eq("single_alu_op", 32'(alu_op), 1);
        cyc();
        check_eq("single_rsp_valid", 32'(rsp_valid), 1);
        check_eq("single_rsp_id", 32'(rsp_id), 0);
        check_eq("single_rsp_result", 32'(rsp_result), 55000);
        check_eq("single_rsp_cc", 32'(rsp_cc), 4'h8);
        check_eq("single_rsp_err", 32'(rsp_err), 0);
        check_eq("single_rsp_busy", 32'(busy), 1);
        cyc();
        check_eq("single_done_valid", 32'(rsp_valid), 0);
        check_eq("single_done_busy", 32'(busy), 0);

        // Contention from reset: both held valid, grants must alternate starting with 0
        reset = 1;
        cyc();
        reset = 0;
        mon_en = 1;
        req0_valid = 1; req0_op = 4'b1111; req0_a = 16'd100;   req0_b = 16'd200;   req0_sub = 0;
        req1_valid = 1; req1_op = 4'b0010; req1_a = 16'd40000; req1_b = 16'd20000; req1_sub = 1;
        #1;
        check_eq("cont_first_ready0", 32'(req0_ready), 1);
        check_eq("cont_first_ready1", 32'(req1_ready), 0);
        for (int i = 0; i < 40 && rsp_ids.size() < 4; i++) cyc();
        req0_valid = 0; req1_valid = 0;
        mon_en = 0;
        check_eq("cont_rsp_count", 32'(rsp_ids.size() >= 4), 1);
        check_eq("cont_grant_count", 32'(grants.size() >= 4), 1);
        check_eq("cont_grant0", 32'(grants[0]), 0);
        check_eq("cont_grant1", 32'(grants[1]), 1);
        check_eq("cont_grant2", 32'(grants[2]), 0);
        check_eq("cont_grant3", 32'(grants[3]), 1);
        check_eq("cont_rsp0_id", 32'(rsp_ids[0]), 0);
        check_eq("cont_rsp0_result", 32'(rsp_results[0]), 20000);
        check_eq("cont_rsp1_id", 32'(rsp_ids[1]), 1);
        check_eq("cont_rsp1_result", 32'(rsp_results[1]), 20000);
        for (int i = 0; i < 10 && busy; i++) cyc();
        check_eq("cont_drain", 32'(busy), 0);

        // Backpressure on requester 1 XOR, requester 0 waiting behind it
        cyc();
        rsp_ready = 0;
        req1_valid = 1; req1_op = 4'b0111; req1_a = 16'hAAAA; req1_b = 16'hAA55; req1_sub = 0;
        #1;
        check_eq("bp_ready1", 32'(req1_ready), 1);
        cyc();
        req1_valid = 0;
        req0_valid = 1; req0_op = 4'b0001; req0_a = 16'd1; req0_b = 16'd2; req0_sub = 0;
        #1;
        check_eq("bp_exec_ready0", 32'(req0_ready), 0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_valid", 32'(rsp_valid), 1);
            check_eq("bp_hold_id", 32'(rsp_id), 1);
            check_eq("bp_hold_result", 32'(rsp_result), 16'h00FF);
            check_eq("bp_hold_cc", 32'(rsp_cc), 0);
            check_eq("bp_hold_ready0", 32'(req0_ready), 0);
            cyc();
        end
        rsp_ready = 1;
        #1;
        check_eq("bp_hs_ready0", 32'(req0_ready), 0);
        cyc();
        check_eq("bp_idle_valid", 32'(rsp_valid), 0);
        check_eq("bp_idle_ready0", 32'(req0_ready), 1);
        cyc();
        req0_valid = 0;
        wait_rsp("bp_next");
        check_eq("bp_next_id", 32'(rsp_id), 0);
        check_eq("bp_next_result", 32'(rsp_result), 3);
        cyc();

        // ALU_LATENCY=3: SHL 0x00FF by 4
        r3_valid = 1; r3_req_op = 4'b1000; r3_req_a = 16'h00FF; r3_req_b = 16'd4;
        #1;
        check_eq("lat3_ready", 32'(r3_ready), 1);
        cyc();
        r3_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq("lat3_alu_a", 32'(r3_valA), 16'h00FF);
            check_eq("lat3_alu_b", 32'(r3_valB), 4);
            check_eq("lat3_no_rsp", 32'(r3_rsp_valid), 0);
            cyc();
        end
        check_eq("lat3_rsp_valid", 32'(r3_rsp_valid), 1);
        check_eq("lat3_rsp_result", 32'(r3_rsp_result), 16'h0FF0);
        cyc();
        check_eq("lat3_done", 32'(r3_rsp_valid), 0);

        // Reset in the middle of EXEC for requester 1 AND
        req1_valid = 1; req1_op = 4'b0101; req1_a = 16'hFF00; req1_b = 16'h00FF; req1_sub = 0;
        cyc();
        req1_valid = 0;
        #1;
        check_eq("rst_mid_in_exec", 32'(busy), 1);
        reset = 1;
        #1;
        check_reset_outputs("rst_mid");
        cyc();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_mid_no_rsp", 32'(rsp_valid), 0);
            cyc();
        end
        req0_valid = 1; req0_op = 4'b0001; req0_a = 16'd5; req0_b = 16'd6;
        req1_valid = 1;
        #1;
        check_eq("rst_mid_tie_ready0", 32'(req0_ready), 1);
        check_eq("rst_mid_tie_ready1", 32'(req1_ready), 0);
        cyc();
        req0_valid = 0; req1_valid = 0;
        wait_rsp("rst_mid_next");
        check_eq("rst_mid_next_result", 32'(rsp_result), 11);
        cyc();

`ifdef ALU_SHARE_ARBITER_OPCHECK_EN
        // Known-good command first so the ALU inputs have a defined previous value
        req0_valid = 1; req0_op = 4'b0001; req0_a = 16'd7; req0_b = 16'd8; req0_sub = 0;
        cyc();
        req0_valid = 0;
        wait_rsp("opc_good");
        check_eq("opc_good_err", 32'(rsp_err), 0);
        check_eq("opc_good_result", 32'(rsp_result), 15);
        cyc();
        req0_valid = 1; req0_op = 4'b0011; req0_a = 16'h1234; req0_b = 16'h5678;
        #1;
        check_eq("opc_bad_ready", 32'(req0_ready), 1);
        cyc();
        req0_valid = 0;
        #1;
        check_eq("opc_bad_valid", 32'(rsp_valid), 1);
        check_eq("opc_bad_err", 32'(rsp_err), 1);
        check_eq("opc_bad_result", 32'(rsp_result), 0);
        check_eq("opc_bad_cc", 32'(rsp_cc), 0);
        check_eq("opc_bad_alu_a", 32'(alu_valA), 7);
        check_eq("opc_bad_alu_op", 32'(alu_op), 1);
        cyc();
        check_eq("opc_bad_done", 32'(rsp_valid), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 16-bit ALU (4-bit opcode, `sub` control, 16-bit result, 4-bit cc) between two requesters.
- Arbitrates round-robin and latches the winner's operands.
- Drives the ALU for a fixed latency, captures result and cc, then returns them on a valid/ready response channel tagged with the requester id.
- Sits between the ALU and two independent command sources, for example two sequencer threads.

Parameters:
- ALU_LATENCY, 1: cycles the ALU inputs are held stable before result/cc are captured. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_op  in  4  requester 0 opcode (ALU encoding).
- req0_a  in  16  requester 0 operand A.
- req0_b  in  16  requester 0 operand B.
- req0_sub  in  1  requester 0 subtract control.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_sub: same as requester 0, for requester 1.
- alu_valA  out  16  operand A to ALU.
- alu_valB  out  16  operand B to ALU.
- alu_op  out  4  opcode to ALU.
- alu_sub  out  1  sub control to ALU.
- alu_result  in  16  ALU result.
- alu_cc  in  4  ALU condition codes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  16  captured result.
- rsp_cc  out  4  captured cc.
- rsp_err  out  1  command rejected (only with the optional feature; otherwise tied 0).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (asynchronous, any state):
  - State returns to IDLE; any in-flight command is dropped and no response is issued.
  - All outputs go to 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
- IDLE:
  - reqN_ready is combinational and is high only in IDLE, only for the granted requester N, and only while reqN_valid = 1.
  - Grant rules:
    - Only one valid requester: that requester is granted.
    - Both valid: the requester that is not last_grant is granted.
  - On the handshake:
    - Latch op, a, b, sub and id.
    - last_grant <= id.
    - Counter <= ALU_LATENCY.
    - Go to EXEC.
  - No valid request: stay in IDLE.
  - Requesters must hold their command until ready; the block samples only on the handshake cycle.
- EXEC:
  - alu_valA/alu_valB/alu_op/alu_sub drive the latched values.
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, alu_result and alu_cc are captured into rsp_result/rsp_cc, and the state moves to RESP.
  - EXEC lasts exactly ALU_LATENCY cycles.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_result, rsp_cc and rsp_err stay stable until rsp_valid && rsp_ready.
  - ALU inputs hold their last values.
  - On the handshake, go to IDLE.
  - No new command is accepted in the handshake cycle itself.
- Outside RESP, rsp_valid = 0. rsp_ready is ignored when rsp_valid = 0.
- Latency and throughput:
  - Command accepted in cycle T; rsp_valid rises in cycle T+ALU_LATENCY+1 (registered transitions).
  - Minimum issue interval with rsp_ready held high is ALU_LATENCY+2 cycles.
- Arithmetic: none is performed here. Results and cc pass through bit-exact, with no width changes.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- Operand latches are written only on the accept handshake. Request input changes during EXEC/RESP have no effect.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_OPCHECK_EN.
- Defined:
  - In IDLE, a granted command whose opcode is 0000, 0011, 0100 or 1010 (unassigned) is still handshaked and updates last_grant.
  - It skips EXEC and goes directly to RESP on the next cycle with rsp_err = 1, rsp_result = 0 and rsp_cc = 0.
  - ALU inputs are not updated.
  - Valid opcodes respond with rsp_err = 0.
- Undefined: every opcode is issued to the ALU and rsp_err is tied 0.

Test Plan:
- Single request: ALU_LATENCY=1, req0 ADD(0001) a=25000 b=30000 sub=0, rsp_ready=1 -> req0_ready for 1 cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_result=55000, busy high throughout.
- Contention: from reset, req0 MUL(1111) 100×200 and req1 SUB(0010) a=40000 b=20000 sub=1, both valid at once -> first response id=0 result=20000; second response id=1 result=20000; then with both held continuously, grants alternate 0,1.
- Backpressure: rsp_ready=0 for 5 cycles during RESP on req1 XOR 0xAAAA^0xAA55 -> rsp_valid, rsp_result=0x00FF and rsp_cc held stable; req0_ready stays 0 until the handshake, then one idle cycle before the next accept.
- Latency parameter: ALU_LATENCY=3, req0 SHL a=0x00FF b=4 -> ALU inputs stable 3 cycles; rsp_valid at T+4 with result=0x0FF0.
- Reset mid-op: assert reset during EXEC of req1 AND 0xFF00&0x00FF -> all outputs 0 immediately, no response afterwards; next simultaneous request from both requesters is granted to req0.
- OPCHECK_EN defined: req0 op=0011 -> accepted, rsp_valid next cycle with rsp_err=1, result=0, cc=0, ALU inputs unchanged; op=0001 still gives rsp_err=0.
